// File: rtl/ddr_init_pkg.sv
// Shared state encoding and default parameters for the DDR bring-up supervisor.
package ddr_init_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAIL  = 2'd3
  } ch_state_e;

  localparam int unsigned DEF_NUM_CH          = 2;
  localparam int unsigned DEF_TIMER_W         = 23;
  localparam int unsigned DEF_RESET_PULSE     = 1023;
  localparam int unsigned DEF_TIMEOUT_COUNT   = 32'h007F_FFFF;
  localparam int unsigned DEF_ITERATION_COUNT = 10;
  localparam int unsigned DEF_ATT_W           = 4;
  localparam int unsigned DEF_READY_STABLE    = 16;
  localparam bit          DEF_FAIL_HOLD_RESET = 1'b0;

endpackage

// File: rtl/ddr_init_retry_ch.sv
// One DDR channel: timed reset pulse, ready-stability filter, timeout retry and attempt count.
module ddr_init_retry_ch
  import ddr_init_pkg::*;
#(
  parameter int unsigned TIMER_W         = DEF_TIMER_W,
  parameter int unsigned RESET_PULSE     = DEF_RESET_PULSE,
  parameter int unsigned TIMEOUT_COUNT   = DEF_TIMEOUT_COUNT,
  parameter int unsigned ITERATION_COUNT = DEF_ITERATION_COUNT,
  parameter int unsigned ATT_W           = DEF_ATT_W,
  parameter int unsigned READY_STABLE    = DEF_READY_STABLE,
  parameter bit          FAIL_HOLD_RESET = DEF_FAIL_HOLD_RESET
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ctrlr_ready,
  input  logic             restart,
  output logic             out_n,
  output logic             done,
  output logic             fail,
  output logic [ATT_W-1:0] attempts,
  output logic             done_c,
  output logic             fail_c
);

  localparam int unsigned STABLE_W = $clog2(READY_STABLE + 1);

  localparam logic [TIMER_W-1:0]  PULSE_LAST   = TIMER_W'(RESET_PULSE - 1);
  localparam logic [TIMER_W-1:0]  TIMEOUT_LAST = TIMER_W'(TIMEOUT_COUNT);
  localparam logic [STABLE_W-1:0] STABLE_MAX   = STABLE_W'(READY_STABLE);
  localparam logic [ATT_W-1:0]    ATT_MAX      = ATT_W'(ITERATION_COUNT);

  ch_state_e            state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [STABLE_W-1:0]  stable_q, stable_d;
  logic [ATT_W-1:0]     att_d;
  logic                 out_n_d;
  logic                 done_d;
  logic                 fail_d;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RESET;
      timer_q  <= '0;
      stable_q <= '0;
      attempts <= '0;
      out_n    <= 1'b0;
      done     <= 1'b0;
      fail     <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      stable_q <= stable_d;
      attempts <= att_d;
      out_n    <= out_n_d;
      done     <= done_d;
      fail     <= fail_d;
    end
  end

  // Next state and next outputs
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    stable_d = stable_q;
    att_d    = attempts;
    out_n_d  = out_n;
    done_d   = done;
    fail_d   = fail;

    case (state_q)
      ST_RESET: begin
        out_n_d  = 1'b0;
        stable_d = '0;
        if (timer_q == PULSE_LAST) begin
          state_d = ST_WAIT;
          timer_d = '0;
          out_n_d = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      ST_WAIT: begin
        out_n_d = 1'b1;
        timer_d = timer_q + TIMER_W'(1);
        if (!ctrlr_ready) begin
          stable_d = '0;
        end else if (stable_q != STABLE_MAX) begin
          stable_d = stable_q + STABLE_W'(1);
        end
        // Training success outranks a coincident timeout
        if (stable_d == STABLE_MAX) begin
          state_d = ST_DONE;
          timer_d = timer_q;
          done_d  = 1'b1;
        end else if (timer_q == TIMEOUT_LAST) begin
          att_d   = attempts + ATT_W'(1);
          timer_d = '0;
          if (att_d == ATT_MAX) begin
            state_d = ST_FAIL;
            fail_d  = 1'b1;
            out_n_d = ~FAIL_HOLD_RESET;
          end else begin
            state_d = ST_RESET;
            out_n_d = 1'b0;
          end
        end
      end

      ST_DONE: begin
        out_n_d = 1'b1;
        done_d  = 1'b1;
      end

      ST_FAIL: begin
        fail_d  = 1'b1;
        out_n_d = ~FAIL_HOLD_RESET;
        if (restart) begin
          state_d  = ST_RESET;
          timer_d  = '0;
          stable_d = '0;
          att_d    = '0;
          fail_d   = 1'b0;
          out_n_d  = 1'b0;
        end
      end
    endcase
  end

  assign done_c = done_d;
  assign fail_c = fail_d;

endmodule

// File: rtl/ddr_init_retry_ctrl.sv
// Multi-channel DDR bring-up supervisor: independent per-channel retry engines plus aggregate flags.
module ddr_init_retry_ctrl
  import ddr_init_pkg::*;
#(
  parameter int unsigned NUM_CH          = DEF_NUM_CH,
  parameter int unsigned TIMER_W         = DEF_TIMER_W,
  parameter int unsigned RESET_PULSE     = DEF_RESET_PULSE,
  parameter int unsigned TIMEOUT_COUNT   = DEF_TIMEOUT_COUNT,
  parameter int unsigned ITERATION_COUNT = DEF_ITERATION_COUNT,
  parameter int unsigned ATT_W           = DEF_ATT_W,
  parameter int unsigned READY_STABLE    = DEF_READY_STABLE,
  parameter bit          FAIL_HOLD_RESET = DEF_FAIL_HOLD_RESET
) (
  input  logic                    clk,
  input  logic                    SYS_RESET_IN_N,
  input  logic [NUM_CH-1:0]       ctrlr_ready,
  input  logic                    restart,
  output logic [NUM_CH-1:0]       SYS_RESET_OUT_N,
  output logic [NUM_CH-1:0]       ch_done,
  output logic [NUM_CH-1:0]       ch_fail,
  output logic [NUM_CH*ATT_W-1:0] attempt_cnt,
  output logic                    all_done,
  output logic                    any_fail
);

  logic [NUM_CH-1:0] done_c;
  logic [NUM_CH-1:0] fail_c;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ddr_init_retry_ch #(
      .TIMER_W         (TIMER_W),
      .RESET_PULSE     (RESET_PULSE),
      .TIMEOUT_COUNT   (TIMEOUT_COUNT),
      .ITERATION_COUNT (ITERATION_COUNT),
      .ATT_W           (ATT_W),
      .READY_STABLE    (READY_STABLE),
      .FAIL_HOLD_RESET (FAIL_HOLD_RESET)
    ) u_ch (
      .clk         (clk),
      .rst_n       (SYS_RESET_IN_N),
      .ctrlr_ready (ctrlr_ready[i]),
      .restart     (restart),
      .out_n       (SYS_RESET_OUT_N[i]),
      .done        (ch_done[i]),
      .fail        (ch_fail[i]),
      .attempts    (attempt_cnt[i*ATT_W +: ATT_W]),
      .done_c      (done_c[i]),
      .fail_c      (fail_c[i])
    );
  end

  // Aggregates built from next-state flags so they line up with ch_done/ch_fail
  always_ff @(posedge clk or negedge SYS_RESET_IN_N) begin
    if (!SYS_RESET_IN_N) begin
      all_done <= 1'b0;
      any_fail <= 1'b0;
    end else begin
      all_done <= &done_c;
      any_fail <= |fail_c;
    end
  end

endmodule

// File: tb/tb_ddr_init_retry_ctrl.sv
// Directed bench for ddr_init_retry_ctrl with small timing parameters and both fail-hold variants.
module tb_ddr_init_retry_ctrl;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned ATT_W  = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_CH-1:0]       ready;
  logic                    restart;
  logic [NUM_CH-1:0]       out_n, done, fail;
  logic [NUM_CH*ATT_W-1:0] att;
  logic                    all_done, any_fail;
  logic [NUM_CH-1:0]       h_out_n, h_done, h_fail;
  logic [NUM_CH*ATT_W-1:0] h_att;
  logic                    h_all_done, h_any_fail;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic low_seen;

  always #5 clk = ~clk;

  ddr_init_retry_ctrl #(
    .NUM_CH(NUM_CH), .TIMER_W(23), .RESET_PULSE(8), .TIMEOUT_COUNT(63),
    .ITERATION_COUNT(3), .ATT_W(ATT_W), .READY_STABLE(4), .FAIL_HOLD_RESET(1'b0)
  ) u_dut (
    .clk(clk), .SYS_RESET_IN_N(rst_n), .ctrlr_ready(ready), .restart(restart),
    .SYS_RESET_OUT_N(out_n), .ch_done(done), .ch_fail(fail), .attempt_cnt(att),
    .all_done(all_done), .any_fail(any_fail)
  );

  ddr_init_retry_ctrl #(
    .NUM_CH(NUM_CH), .TIMER_W(23), .RESET_PULSE(8), .TIMEOUT_COUNT(63),
    .ITERATION_COUNT(3), .ATT_W(ATT_W), .READY_STABLE(4), .FAIL_HOLD_RESET(1'b1)
  ) u_dut_hold (
    .clk(clk), .SYS_RESET_IN_N(rst_n), .ctrlr_ready(ready), .restart(restart),
    .SYS_RESET_OUT_N(h_out_n), .ch_done(h_done), .ch_fail(h_fail), .attempt_cnt(h_att),
    .all_done(h_all_done), .any_fail(h_any_fail)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; afterwards outputs reflect cyc edges since the reference point
  task automatic cycle();
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    rst_n = 1'b0; ready = '0; restart = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_n",    32'(out_n),    32'h0);
    chk("rst_done",     32'(done),     32'h0);
    chk("rst_fail",     32'(fail),     32'h0);
    chk("rst_att",      32'(att),      32'h0);
    chk("rst_all_done", 32'(all_done), 32'h0);
    chk("rst_any_fail", 32'(any_fail), 32'h0);

    // No ready: three full attempts then FAIL
    rst_n = 1'b1; cyc = 0;
    while (cyc < 216) begin
      cycle();
      if (cyc == 7)  chk("a_pulse_low", 32'(out_n), 32'h0);
      if (cyc == 8)  chk("a_pulse_rel", 32'(out_n), 32'h3);
      if (cyc == 71) chk("a_wait_end",  32'(out_n), 32'h3);
      if (cyc == 72) begin
        chk("a_retry1_out_n", 32'(out_n), 32'h0);
        chk("a_retry1_att",   32'(att),   32'h11);
      end
      if (cyc == 215) begin
        chk("a_prefail_fail", 32'(fail), 32'h0);
        chk("a_prefail_att",  32'(att),  32'h22);
      end
      if (cyc == 216) begin
        chk("a_fail",        32'(fail),     32'h3);
        chk("a_any_fail",    32'(any_fail), 32'h1);
        chk("a_fail_att",    32'(att),      32'h33);
        chk("a_fail_out_n",  32'(out_n),    32'h3);
        chk("a_hold_out_n",  32'(h_out_n),  32'h0);
      end
    end
    repeat (20) cycle();
    chk("a_fail_sticky", 32'(fail),    32'h3);
    chk("a_rel_steady",  32'(out_n),   32'h3);
    chk("a_hold_steady", 32'(h_out_n), 32'h0);
    chk("a_hold_fail",   32'(h_fail),  32'h3);

    // Restart both failed channels
    restart = 1'b1; cycle(); restart = 1'b0; cyc = 0;
    chk("r_out_n",      32'(out_n),    32'h0);
    chk("r_fail",       32'(fail),     32'h0);
    chk("r_att",        32'(att),      32'h0);
    chk("r_any_fail",   32'(any_fail), 32'h0);
    chk("r_hold_out_n", 32'(h_out_n),  32'h0);
    chk("r_hold_fail",  32'(h_fail),   32'h0);

    // ch0 trains in first WAIT; ch1 sees 3-high/1-low and keeps retrying
    low_seen = 1'b0;
    while (cyc < 216) begin
      ready[0] = (cyc + 1 >= 19);
      ready[1] = ((cyc + 1) % 4 != 0);
      cycle();
      if (cyc >= 8 && out_n[0] == 1'b0) low_seen = 1'b1;
      if (cyc == 21) chk("b_done_early", 32'(done), 32'h0);
      if (cyc == 22) begin
        chk("b_done0",     32'(done),     32'h1);
        chk("b_done0_att", 32'(att),      32'h0);
        chk("b_all_done",  32'(all_done), 32'h0);
      end
      if (cyc == 72)  chk("b_ch1_att1", 32'(att), 32'h10);
      if (cyc == 144) chk("b_ch1_att2", 32'(att), 32'h20);
      if (cyc == 216) begin
        chk("b_fail",        32'(fail),     32'h2);
        chk("b_done",        32'(done),     32'h1);
        chk("b_any_fail",    32'(any_fail), 32'h1);
        chk("b_att",         32'(att),      32'h30);
        chk("b_out_n",       32'(out_n),    32'h3);
        chk("b_hold_out_n",  32'(h_out_n),  32'h1);
      end
    end
    chk("b_ch0_no_repulse", 32'(low_seen), 32'h0);

    ready = '0;
    repeat (10) cycle();
    chk("b_done_sticky",  32'(done),  32'h1);
    chk("b_out_n_sticky", 32'(out_n), 32'h3);

    // Restart ignored by DONE ch0; ch1 hits 4th ready cycle exactly at timeout
    restart = 1'b1; cycle(); restart = 1'b0; cyc = 0;
    chk("c_out_n", 32'(out_n), 32'h1);
    chk("c_done",  32'(done),  32'h1);
    chk("c_fail",  32'(fail),  32'h0);
    chk("c_att",   32'(att),   32'h0);
    while (cyc < 72) begin
      ready[1] = (cyc + 1 >= 69);
      cycle();
      if (cyc == 71) begin
        chk("c_pre_done",     32'(done),     32'h1);
        chk("c_pre_all_done", 32'(all_done), 32'h0);
      end
      if (cyc == 72) begin
        chk("c_tie_done",     32'(done),     32'h3);
        chk("c_tie_all_done", 32'(all_done), 32'h1);
        chk("c_tie_att",      32'(att),      32'h0);
        chk("c_tie_out_n",    32'(out_n),    32'h3);
      end
    end

    // Asynchronous reset while everything is done
    #2 rst_n = 1'b0;
    #1;
    chk("d_async_done",     32'(done),     32'h0);
    chk("d_async_all_done", 32'(all_done), 32'h0);
    chk("d_async_out_n",    32'(out_n),    32'h0);
    ready = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; cyc = 0;

    // Reach attempt 2 mid-WAIT, then reset again
    while (cyc < 154) cycle();
    chk("d_mid_att",   32'(att),   32'h22);
    chk("d_mid_out_n", 32'(out_n), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("d_async_att",      32'(att),      32'h0);
    chk("d_async_out_n2",   32'(out_n),    32'h0);
    chk("d_async_fail",     32'(fail),     32'h0);
    chk("d_async_any_fail", 32'(any_fail), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; cyc = 0;

    // Full sequence restarts; ch0's 4th ready cycle lands one edge after timeout
    while (cyc < 145) begin
      ready[0] = (cyc + 1 >= 142) && (cyc + 1 <= 145);
      cycle();
      if (cyc == 7) chk("e_pulse_low", 32'(out_n), 32'h0);
      if (cyc == 8) chk("e_pulse_rel", 32'(out_n), 32'h3);
      if (cyc == 72) begin
        chk("e_att1",   32'(att),   32'h11);
        chk("e_out_n1", 32'(out_n), 32'h0);
      end
      if (cyc == 144) begin
        chk("e_late_att",   32'(att),   32'h22);
        chk("e_late_done",  32'(done),  32'h0);
        chk("e_late_out_n", 32'(out_n), 32'h0);
      end
      if (cyc == 145) chk("e_reset_ignores_ready", 32'(done), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ddr_init_retry_ctrl.md
Name: ddr_init_retry_ctrl

Overview:
Multi-channel DDR controller bring-up supervisor. It issues a timed reset pulse per channel, waits for that channel's controller-ready, and re-pulses on timeout up to a retry limit. Each channel retries independently, so a channel that has trained is never reset again while others keep retrying. It sits between the board reset and each DDR controller's reset input, and reports per-channel done/fail/attempt status plus aggregate flags to the fabric.

Parameters:
NUM_CH, 2, number of independent DDR channels (1..8)
TIMER_W, 23, width of the per-channel phase timer
RESET_PULSE, 1023, cycles the channel reset is held low per attempt (1..2^TIMER_W-1)
TIMEOUT_COUNT, 23'h7FFFFF, final timer value in WAIT; a timeout fires when the timer equals this value
ITERATION_COUNT, 10, maximum attempts per channel before FAIL (1..2^ATT_W-1)
ATT_W, 4, attempt counter width
READY_STABLE, 16, consecutive high cycles of ctrlr_ready needed to declare a channel done (>=1)
FAIL_HOLD_RESET, 0, 1 = FAIL channel holds its reset low; 0 = FAIL channel releases its reset high

Ports:
clk  in  1  system clock, all logic on its rising edge
SYS_RESET_IN_N  in  1  asynchronous active-low reset
ctrlr_ready  in  NUM_CH  per-channel controller ready, synchronous to clk
restart  in  1  single-cycle pulse: re-arms every channel currently in FAIL
SYS_RESET_OUT_N  out  NUM_CH  per-channel active-low reset to each DDR controller
ch_done  out  NUM_CH  channel has trained (sticky)
ch_fail  out  NUM_CH  channel exhausted ITERATION_COUNT attempts
attempt_cnt  out  NUM_CH*ATT_W  completed attempts per channel, channel i at [i*ATT_W +: ATT_W]
all_done  out  1  registered AND of ch_done
any_fail  out  1  registered OR of ch_fail

Behaviour:
- Reset (SYS_RESET_IN_N low, asynchronous): every channel enters RESET with timer=0, attempts=0 and stable=0. All outputs are 0, including SYS_RESET_OUT_N, which is therefore asserted.
- Per-channel FSM, encoded as RESET, WAIT, DONE and FAIL. All outputs are registered.
- RESET: out_n=0. The timer increments each cycle. When timer==RESET_PULSE-1, go to WAIT, clear timer to 0, and set out_n=1 on the same edge. The reset is low for exactly RESET_PULSE cycles. ctrlr_ready is ignored and stable is held at 0.
- WAIT: out_n=1, and the timer increments.
  - stable counter: increments while ctrlr_ready[i]=1, saturating at READY_STABLE; it clears on any low cycle.
  - If stable reaches READY_STABLE this cycle, go to DONE.
  - Otherwise, if timer==TIMEOUT_COUNT, set attempts+1. If the new attempts value equals ITERATION_COUNT, go to FAIL; otherwise go to RESET with timer=0.
  - If the stable threshold and the timeout occur in the same cycle, DONE wins and attempts is not incremented.
- DONE: out_n=1 and ch_done=1, both sticky until SYS_RESET_IN_N. Later drops of ctrlr_ready are ignored. The timer is frozen.
- FAIL: ch_fail=1 and out_n=~FAIL_HOLD_RESET. The timer is frozen.
  - restart=1 in FAIL: go to RESET, clear attempts/timer/stable, set ch_fail=0 and out_n=0 on the next edge.
  - restart is ignored in the RESET, WAIT and DONE states.
- attempt_cnt is updated on the timeout edge and never wraps, because ITERATION_COUNT < 2^ATT_W.
- all_done and any_fail are registered from the next-state flags, so they are valid in the same cycle as ch_done and ch_fail.
- Attempt period is RESET_PULSE + TIMEOUT_COUNT + 1 cycles.
- Channels share no state, and simultaneous events on different channels are independent.
- SYS_RESET_IN_N asserted mid-attempt: immediate return to the reset state defined above.

Decomposition:
- Package ddr_init_pkg holds the state encoding constants (ST_RESET=2'd0, ST_WAIT=2'd1, ST_DONE=2'd2, ST_FAIL=2'd3) and the default-parameter constants.
- Sub-module ddr_init_retry_ch (one channel: FSM, timer, stable counter, attempt counter) is instantiated NUM_CH times in a generate loop.
- The top level holds only the generate loop, the output packing and the aggregate registers.

Test Plan:
All scenarios use NUM_CH=2, RESET_PULSE=8, TIMEOUT_COUNT=63, ITERATION_COUNT=3, READY_STABLE=4, ATT_W=4.
- Release SYS_RESET_IN_N, hold ctrlr_ready=0 -> each SYS_RESET_OUT_N goes low for 8 cycles and high for 64, three times. ch_fail rises 216 cycles after release, attempt_cnt=3 per channel, any_fail=1, outputs stay high (FAIL_HOLD_RESET=0).
- Raise ctrlr_ready[0] 10 cycles into the first WAIT and hold it -> ch_done[0] rises 4 cycles later with attempt_cnt[0]=0. Channel 1 keeps retrying and SYS_RESET_OUT_N[0] never goes low again.
- Toggle ctrlr_ready[1] in a 3-high/1-low pattern -> ch_done[1] never sets, and each timeout increments attempt_cnt[1].
- Make the 4th consecutive ready-high cycle coincide with timer==63 -> DONE is taken and attempt_cnt is unchanged.
- With both channels in FAIL, pulse restart -> next edge SYS_RESET_OUT_N=0, ch_fail=0, attempt_cnt=0. Repeat with FAIL_HOLD_RESET=1 and check that outputs stay low while in FAIL.
- Assert SYS_RESET_IN_N low mid-WAIT on an attempt=2 channel -> all outputs go to 0 asynchronously, and the full sequence restarts on release.
